// File: rtl/dest_demux_pkg.sv
// Shared definitions for the transaction-layer routing blocks.
//   NUM_DEST : number of destination queues
//   DATA_W   : payload width
//   DEST_W   : destination tag width
//   entry_t  : {dest, data} word stored in each queue
package dest_demux_pkg;

    localparam int unsigned NUM_DEST = 4;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned DEST_W   = 4;
    localparam int unsigned IDX_W    = $clog2(NUM_DEST);
    localparam int unsigned CNT_W    = 8;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == {CNT_W{1'b1}}) ? x : x + CNT_W'(1);
    endfunction

endpackage

// File: rtl/dest_demux_if.sv
// Producer-side push bus of the destination demultiplexer.
//   data_in/dest_in/push_in : word, tag and valid from the producer
//   ready_out               : addressed queue can take a word this cycle
interface dest_demux_if;
    import dest_demux_pkg::*;

    logic [DATA_W-1:0] data_in;
    logic [DEST_W-1:0] dest_in;
    logic              push_in;
    logic              ready_out;

    modport master (output data_in, output dest_in, output push_in, input ready_out);
    modport slave  (input data_in, input dest_in, input push_in, output ready_out);
endinterface

// File: rtl/dest_demux_fifo_sync.sv
// Single-clock first-word-fall-through queue of {dest, data} entries.
//   clk, rst_n     : clock, async active-low reset
//   push_i, wdata_i: write request and entry (ignored while full)
//   pop_i          : consume head (ignored while empty)
//   rdata_o        : head entry, zero while empty
//   empty_o, full_o, almost_full_o : occupancy flags
module fifo_sync
    import dest_demux_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = DEPTH - 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  entry_t wdata_i,
    input  logic   pop_i,
    output entry_t rdata_o,
    output logic   empty_o,
    output logic   full_o,
    output logic   almost_full_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == CW'(DEPTH));
    assign almost_full_o = (count_q >= CW'(AF_LEVEL));
    assign rdata_o       = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer/count next state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are invisible while count is zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dest_demux.sv
// Routes tagged words into one of four FWFT queues and reports rejected pushes.
//   clk, reset_L      : clock, async active-low reset
//   in_if             : push bus (data_in, dest_in, push_in, ready_out)
//   pop0..pop3        : consumer reads of queue i
//   data_out/dest_out : head of queue i, zero while empty
//   empty/full/almost_full : occupancy flags of queue i
//   drop_err, ovf_err : one-cycle pulses for invalid tag / push to full queue
//   drop_cnt          : saturating count of rejected pushes
module dest_demux
    import dest_demux_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = DEPTH - 1
) (
    input  logic              clk,
    input  logic              reset_L,
    dest_demux_if.slave       in_if,
    input  logic              pop0,
    input  logic              pop1,
    input  logic              pop2,
    input  logic              pop3,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] data_out3,
    output logic [DEST_W-1:0] dest_out0,
    output logic [DEST_W-1:0] dest_out1,
    output logic [DEST_W-1:0] dest_out2,
    output logic [DEST_W-1:0] dest_out3,
    output logic              empty0,
    output logic              empty1,
    output logic              empty2,
    output logic              empty3,
    output logic              full0,
    output logic              full1,
    output logic              full2,
    output logic              full3,
    output logic              almost_full0,
    output logic              almost_full1,
    output logic              almost_full2,
    output logic              almost_full3,
    output logic              drop_err,
    output logic              ovf_err,
    output logic [CNT_W-1:0]  drop_cnt
);
    entry_t              wdata;
    entry_t              head    [NUM_DEST];
    logic [NUM_DEST-1:0] pop_v, push_v, empty_v, full_v, af_v;
    logic [IDX_W-1:0]    dest_idx;
    logic                valid_tag, ready_c;

    logic                drop_err_q, drop_err_d;
    logic                ovf_err_q, ovf_err_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    assign pop_v     = {pop3, pop2, pop1, pop0};
    assign valid_tag = (in_if.dest_in < DEST_W'(NUM_DEST));
    assign dest_idx  = in_if.dest_in[IDX_W-1:0];
    // Uses the current full flag, so a same-cycle pop never makes room.
    assign ready_c   = valid_tag && !full_v[dest_idx];
    assign in_if.ready_out = ready_c;
    assign wdata     = '{dest: in_if.dest_in, data: in_if.data_in};

    for (genvar g = 0; g < NUM_DEST; g++) begin : g_q
        assign push_v[g] = in_if.push_in && ready_c && (dest_idx == IDX_W'(g));
        fifo_sync #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) u_fifo (
            .clk           (clk),
            .rst_n         (reset_L),
            .push_i        (push_v[g]),
            .wdata_i       (wdata),
            .pop_i         (pop_v[g]),
            .rdata_o       (head[g]),
            .empty_o       (empty_v[g]),
            .full_o        (full_v[g]),
            .almost_full_o (af_v[g])
        );
    end

    assign data_out0 = head[0].data;
    assign data_out1 = head[1].data;
    assign data_out2 = head[2].data;
    assign data_out3 = head[3].data;
    assign dest_out0 = head[0].dest;
    assign dest_out1 = head[1].dest;
    assign dest_out2 = head[2].dest;
    assign dest_out3 = head[3].dest;
    assign {empty3, empty2, empty1, empty0}                     = empty_v;
    assign {full3, full2, full1, full0}                         = full_v;
    assign {almost_full3, almost_full2, almost_full1, almost_full0} = af_v;

    // Rejected-push classification; at most one event per cycle.
    always_comb begin
        drop_err_d = 1'b0;
        ovf_err_d  = 1'b0;
        drop_cnt_d = drop_cnt_q;
        if (in_if.push_in) begin
            drop_err_d = !valid_tag;
            ovf_err_d  = valid_tag && !ready_c;
        end
        if (drop_err_d || ovf_err_d) drop_cnt_d = sat_inc(drop_cnt_q);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            drop_err_q <= 1'b0;
            ovf_err_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            drop_err_q <= drop_err_d;
            ovf_err_q  <= ovf_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_err = drop_err_q;
    assign ovf_err  = ovf_err_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_dest_demux.sv
module tb_dest_demux;
    localparam int DEPTH = 4;
    localparam int AF    = DEPTH - 1;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       pop [4];
    logic [7:0] dout [4];
    logic [3:0] tout [4];
    logic       emp [4];
    logic       ful [4];
    logic       afl [4];
    logic       drop_err, ovf_err;
    logic [7:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue of {dest,data} per destination.
    logic [11:0] mq [4][$];
    logic        m_drop, m_ovf;
    int          m_cnt;

    dest_demux_if in_if ();

    dest_demux #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_L(reset_L), .in_if(in_if),
        .pop0(pop[0]), .pop1(pop[1]), .pop2(pop[2]), .pop3(pop[3]),
        .data_out0(dout[0]), .data_out1(dout[1]), .data_out2(dout[2]), .data_out3(dout[3]),
        .dest_out0(tout[0]), .dest_out1(tout[1]), .dest_out2(tout[2]), .dest_out3(tout[3]),
        .empty0(emp[0]), .empty1(emp[1]), .empty2(emp[2]), .empty3(emp[3]),
        .full0(ful[0]), .full1(ful[1]), .full2(ful[2]), .full3(ful[3]),
        .almost_full0(afl[0]), .almost_full1(afl[1]), .almost_full2(afl[2]), .almost_full3(afl[3]),
        .drop_err(drop_err), .ovf_err(ovf_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_drop = 1'b0;
        m_ovf  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            logic e;
            e = (mq[i].size() == 0);
            chk($sformatf("%s_empty%0d", tag, i), 32'(emp[i]), 32'(e));
            chk($sformatf("%s_full%0d", tag, i), 32'(ful[i]), 32'(mq[i].size() == DEPTH));
            chk($sformatf("%s_af%0d", tag, i), 32'(afl[i]), 32'(mq[i].size() >= AF));
            chk($sformatf("%s_data%0d", tag, i), 32'(dout[i]), e ? 32'd0 : 32'(mq[i][0][7:0]));
            chk($sformatf("%s_dest%0d", tag, i), 32'(tout[i]), e ? 32'd0 : 32'(mq[i][0][11:8]));
        end
        chk({tag, "_drop_err"}, 32'(drop_err), 32'(m_drop));
        chk({tag, "_ovf_err"}, 32'(ovf_err), 32'(m_ovf));
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(m_cnt));
    endtask

    // One clock: drive, check ready, clock, update model, check outputs.
    task automatic step(input string tag, input logic push, input logic [3:0] dest,
                        input logic [7:0] data, input logic [3:0] pops);
        bit acc;
        int d;
        in_if.push_in = push;
        in_if.dest_in = dest;
        in_if.data_in = data;
        for (int i = 0; i < 4; i++) pop[i] = pops[i];
        d = int'(dest);
        acc = (d < 4) && (mq[d % 4].size() < DEPTH);
        #1;
        chk({tag, "_ready"}, 32'(in_if.ready_out), 32'(acc));
        @(posedge clk);
        for (int i = 0; i < 4; i++)
            if (pops[i] && mq[i].size() > 0) void'(mq[i].pop_front());
        if (push && acc) mq[d].push_back({dest, data});
        m_drop = push && (d >= 4);
        m_ovf  = push && (d < 4) && !acc;
        if ((m_drop || m_ovf) && m_cnt < 255) m_cnt++;
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_L = 1'b0;
        in_if.push_in = 1'b0;
        in_if.dest_in = '0;
        in_if.data_in = '0;
        for (int i = 0; i < 4; i++) pop[i] = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_all("reset");
        @(negedge clk);
        reset_L = 1'b1;

        // Routing
        step("route", 1'b1, 4'd2, 8'hA5, 4'b0000);
        chk("route_data2_const", 32'(dout[2]), 32'hA5);
        chk("route_dest2_const", 32'(tout[2]), 32'd2);
        step("idle", 1'b0, 4'd0, 8'h00, 4'b0100);

        // Full and overflow on dest 1
        for (int k = 0; k < 5; k++) step($sformatf("fill%0d", k), 1'b1, 4'd1, 8'(8'h10 + k), 4'b0000);
        chk("ovf_cnt_const", 32'(drop_cnt), 32'd1);
        step("ovf_clear", 1'b0, 4'd0, 8'h00, 4'b0000);
        // Full queue with same-cycle pop still rejects the push
        step("full_pop", 1'b1, 4'd1, 8'h77, 4'b0010);
        for (int k = 0; k < 4; k++) step("drain1", 1'b0, 4'd0, 8'h00, 4'b0010);

        // Invalid tag
        step("badtag", 1'b1, 4'd7, 8'h5A, 4'b0000);
        step("badtag15", 1'b1, 4'd15, 8'h5B, 4'b0000);

        // Ordering and wrap on dest 3
        for (int k = 0; k < 10; k++)
            step($sformatf("wrap%0d", k), 1'b1, 4'd3, 8'(k), (k % 2 == 1) ? 4'b1000 : 4'b0000);
        for (int k = 0; k < 6; k++) step("wrap_drain", 1'b0, 4'd0, 8'h00, 4'b1000);

        // Simultaneous push/pop
        step("pp_fill0", 1'b1, 4'd0, 8'hC0, 4'b0000);
        step("pp_fill1", 1'b1, 4'd0, 8'hC1, 4'b0000);
        step("pp_both", 1'b1, 4'd0, 8'hC2, 4'b0001);
        step("pp_d0", 1'b0, 4'd0, 8'h00, 4'b0001);
        step("pp_d1", 1'b0, 4'd0, 8'h00, 4'b0001);
        step("pp_empty", 1'b1, 4'd0, 8'hC3, 4'b0001);
        step("pp_pop_all", 1'b0, 4'd0, 8'h00, 4'b1111);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            logic [3:0] rd;
            logic [3:0] rp;
            rd = 4'($urandom_range(0, 5));
            rp = 4'($urandom) & 4'($urandom);
            step("rnd", ($urandom % 4) != 0, rd, 8'($urandom), rp);
        end
        step("rnd_pop_all", 1'b0, 4'd0, 8'h00, 4'b1111);

        // drop_cnt saturation
        for (int k = 0; k < 260; k++) step("sat", 1'b1, 4'd9, 8'($urandom), 4'b0000);
        chk("sat_cnt_const", 32'(drop_cnt), 32'd255);

        // Async reset mid-burst
        step("burst0", 1'b1, 4'd0, 8'h21, 4'b0000);
        step("burst1", 1'b1, 4'd2, 8'h22, 4'b0000);
        step("burst2", 1'b1, 4'd8, 8'h23, 4'b0000);
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset_L = 1'b1;
        step("post_rst", 1'b1, 4'd1, 8'h3C, 4'b0000);
        chk("post_rst_data1_const", 32'(dout[1]), 32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
